// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction fetch/decode/dispatch sequencer for the vector compute units
module instr_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] base_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [63:0]     imem_rdata,
  input  logic            imem_valid,
  output logic            mem_start,
  output logic            gemv_start,
  output logic            relu_start,
  output logic [1:0]      mem_op,
  input  logic            mem_done,
  input  logic            gemv_done,
  input  logic            relu_done,
  output logic [4:0]      dest,
  output logic [9:0]      len_cols,
  output logic [9:0]      rows,
  output logic [23:0]     addr,
  output logic [4:0]      b,
  output logic [4:0]      x,
  output logic [4:0]      w,
  output logic            busy,
  output logic            halted,
  output logic            error,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     instr_count
);

  localparam logic [4:0] OP_NOP    = 5'h00;
  localparam logic [4:0] OP_LOAD_V = 5'h01;
  localparam logic [4:0] OP_LOAD_M = 5'h02;
  localparam logic [4:0] OP_STORE  = 5'h03;
  localparam logic [4:0] OP_GEMV   = 5'h04;
  localparam logic [4:0] OP_RELU   = 5'h05;
  localparam logic [4:0] OP_HALT   = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DISPATCH,
    S_WAIT_DONE,
    S_HALTED
  } state_t;

  state_t      state;
  logic [63:0] instr;
  logic [4:0]  op;
  logic [4:0]  opcode;
  logic        unit_done;

  assign opcode    = instr[4:0];
  assign imem_addr = pc;

  // Completion pulse from the unit owning the in-flight instruction; other units' pulses never reach the FSM
  always_comb begin
    unit_done = 1'b0;
    case (op)
      OP_LOAD_V, OP_LOAD_M, OP_STORE: unit_done = mem_done;
      OP_GEMV:                        unit_done = gemv_done;
      OP_RELU:                        unit_done = relu_done;
      default:                        unit_done = 1'b0;
    endcase
  end

  // Sequencer FSM; start pulses are raised in DECODE so they are visible exactly during DISPATCH,
  // which makes a done arriving alongside the start pulse fall outside WAIT_DONE and be ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr       <= '0;
      op          <= '0;
      imem_req    <= 1'b0;
      mem_start   <= 1'b0;
      gemv_start  <= 1'b0;
      relu_start  <= 1'b0;
      mem_op      <= 2'b00;
      dest        <= '0;
      len_cols    <= '0;
      rows        <= '0;
      addr        <= '0;
      b           <= '0;
      x           <= '0;
      w           <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
      pc          <= '0;
      instr_count <= '0;
    end else begin
      mem_start  <= 1'b0;
      gemv_start <= 1'b0;
      relu_start <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc          <= base_pc;
            error       <= 1'b0;
            instr_count <= '0;
            imem_req    <= 1'b1;
            busy        <= 1'b1;
            halted      <= 1'b0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          op       <= opcode;
          mem_op   <= 2'b00;
          dest     <= '0;
          len_cols <= '0;
          rows     <= '0;
          addr     <= '0;
          b        <= '0;
          x        <= '0;
          w        <= '0;
          case (opcode)
            OP_NOP: begin
              pc          <= pc + PC_W'(1);
              instr_count <= instr_count + 16'd1;
              imem_req    <= 1'b1;
              state       <= S_FETCH;
            end
            OP_LOAD_V, OP_LOAD_M, OP_STORE: begin
              dest     <= instr[9:5];
              len_cols <= instr[19:10];
              addr     <= instr[63:40];
              if (opcode == OP_LOAD_M) rows <= instr[29:20];
              mem_op    <= (opcode == OP_LOAD_V) ? 2'b01 :
                           (opcode == OP_LOAD_M) ? 2'b10 : 2'b11;
              mem_start <= 1'b1;
              state     <= S_DISPATCH;
            end
            OP_GEMV: begin
              dest       <= instr[9:5];
              len_cols   <= instr[19:10];
              rows       <= instr[29:20];
              b          <= instr[34:30];
              x          <= instr[39:35];
              w          <= instr[44:40];
              gemv_start <= 1'b1;
              state      <= S_DISPATCH;
            end
            OP_RELU: begin
              dest       <= instr[9:5];
              x          <= instr[14:10];
              len_cols   <= instr[29:20];
              relu_start <= 1'b1;
              state      <= S_DISPATCH;
            end
            OP_HALT: begin
              instr_count <= instr_count + 16'd1;
              busy        <= 1'b0;
              halted      <= 1'b1;
              state       <= S_HALTED;
            end
            default: begin
              error  <= 1'b1;
              busy   <= 1'b0;
              halted <= 1'b1;
              state  <= S_HALTED;
            end
          endcase
        end
        S_DISPATCH: begin
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (unit_done) begin
            pc          <= pc + PC_W'(1);
            instr_count <= instr_count + 16'd1;
            imem_req    <= 1'b1;
            state       <= S_FETCH;
          end
        end
        default: begin
          imem_req <= 1'b0;
          busy     <= 1'b0;
          halted   <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer against a program-level model
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  base_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [63:0] imem_rdata;
  logic        imem_valid;
  logic        mem_start, gemv_start, relu_start;
  logic [1:0]  mem_op;
  logic        mem_done, gemv_done, relu_done;
  logic [4:0]  dest, b, x, w;
  logic [9:0]  len_cols, rows;
  logic [23:0] addr;
  logic        busy, halted, error;
  logic [7:0]  pc;
  logic [15:0] instr_count;

  // record: unit(0 mem,1 gemv,2 relu), mem_op, dest, len_cols, rows, addr, b, x, w
  typedef logic [67:0] rec_t;

  logic [63:0] imem [256];
  rec_t        exp_q [$];
  rec_t        obs_q [$];
  int          lat_q [$];
  int          unstable, multi;
  bit          timed_out;
  int          vectors = 0;
  int          miscompares = 0;

  assign imem_rdata = imem[imem_addr];

  instr_sequencer #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_pc(base_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .mem_start(mem_start), .gemv_start(gemv_start), .relu_start(relu_start), .mem_op(mem_op),
    .mem_done(mem_done), .gemv_done(gemv_done), .relu_done(relu_done),
    .dest(dest), .len_cols(len_cols), .rows(rows), .addr(addr), .b(b), .x(x), .w(w),
    .busy(busy), .halted(halted), .error(error), .pc(pc), .instr_count(instr_count)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [65:0] cur_fields();
    return {mem_op, dest, len_cols, rows, addr, b, x, w};
  endfunction

  function automatic logic [104:0] all_outs();
    return {busy, halted, error, pc, instr_count, imem_req, mem_start, gemv_start, relu_start,
            mem_op, dest, len_cols, rows, addr, b, x, w, imem_addr};
  endfunction

  function automatic rec_t mk(input logic [1:0] u, input logic [1:0] mo, input logic [4:0] d,
                              input logic [9:0] l, input logic [9:0] r, input logic [23:0] a,
                              input logic [4:0] bb, input logic [4:0] xx, input logic [4:0] ww);
    return {u, mo, d, l, r, a, bb, xx, ww};
  endfunction

  function automatic logic [63:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // Program-level reference: walk memory applying the ISA rules and list the expected dispatches
  task automatic model(input logic [7:0] bpc, output logic [7:0] pce, output logic [15:0] cnte,
                       output logic erre);
    logic [63:0] iw;
    logic [7:0]  p;
    p = bpc; cnte = 0; erre = 0;
    exp_q.delete();
    for (int s = 0; s < 300; s++) begin
      iw = imem[p];
      case (iw[4:0])
        5'h00: begin p++; cnte++; end
        5'h01, 5'h03: begin
          exp_q.push_back(mk(2'd0, (iw[4:0] == 5'h01) ? 2'd1 : 2'd3, iw[9:5], iw[19:10], 10'd0,
                             iw[63:40], 5'd0, 5'd0, 5'd0));
          p++; cnte++;
        end
        5'h02: begin
          exp_q.push_back(mk(2'd0, 2'd2, iw[9:5], iw[19:10], iw[29:20], iw[63:40], 5'd0, 5'd0, 5'd0));
          p++; cnte++;
        end
        5'h04: begin
          exp_q.push_back(mk(2'd1, 2'd0, iw[9:5], iw[19:10], iw[29:20], 24'd0, iw[34:30], iw[39:35],
                             iw[44:40]));
          p++; cnte++;
        end
        5'h05: begin
          exp_q.push_back(mk(2'd2, 2'd0, iw[9:5], iw[29:20], 10'd0, 24'd0, 5'd0, iw[14:10], 5'd0));
          p++; cnte++;
        end
        5'h1F: begin cnte++; break; end
        default: begin erre = 1; break; end
      endcase
    end
    pce = p;
  endtask

  // Starts the sequencer at bpc and acts as instruction memory and the three units until HALTED;
  // records every dispatch, done-to-start latency, field instability in WAIT and illegal starts
  task automatic run_prog(input logic [7:0] bpc, input int max_cyc, input bit stall, input bit noise,
                          input int fixed_wait);
    rec_t       cur;
    logic [1:0] sel;
    bit         waiting;
    int         wait_left, last_done, ns, k;
    obs_q.delete(); lat_q.delete();
    unstable = 0; multi = 0; timed_out = 1; waiting = 0; wait_left = 0; last_done = -1;
    sel = 2'd0; cur = '0;
    @(negedge clk);
    start = 1'b1; base_pc = bpc; imem_valid = 1'b0;
    {relu_done, gemv_done, mem_done} = 3'b000;
    @(negedge clk);
    for (int c = 0; c < max_cyc; c++) begin
      start = 1'b0;
      {relu_done, gemv_done, mem_done} = 3'b000;
      if (halted) begin timed_out = 0; break; end
      imem_valid = imem_req && (!stall || ($urandom_range(0, 2) != 0));
      ns = int'(mem_start) + int'(gemv_start) + int'(relu_start);
      if (ns > 1 || (ns != 0 && waiting)) multi++;
      if (ns != 0) begin
        sel = mem_start ? 2'd0 : (gemv_start ? 2'd1 : 2'd2);
        cur = {sel, cur_fields()};
        obs_q.push_back(cur);
        if (last_done >= 0) lat_q.push_back(c - last_done);
        waiting = 1;
        wait_left = (fixed_wait > 0) ? fixed_wait : int'($urandom_range(1, 6));
        if (noise && $urandom_range(0, 1) == 1) {relu_done, gemv_done, mem_done} = 3'b001 << sel;
      end else if (waiting) begin
        if (cur_fields() !== cur[65:0] || !busy) unstable++;
        wait_left--;
        if (wait_left == 0) begin
          {relu_done, gemv_done, mem_done} = 3'b001 << sel;
          waiting = 0;
          last_done = c;
        end else if (noise) begin
          k = (int'(sel) + int'($urandom_range(1, 2))) % 3;
          {relu_done, gemv_done, mem_done} = 3'b001 << k;
        end
      end else if (noise && $urandom_range(0, 3) == 0) begin
        {relu_done, gemv_done, mem_done} = 3'b001 << $urandom_range(0, 2);
      end
      if (noise && $urandom_range(0, 7) == 0) begin
        start = 1'b1; base_pc = 8'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0; imem_valid = 1'b0;
    {relu_done, gemv_done, mem_done} = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_pc = 8'h00; imem_valid = 1'b0;
    {relu_done, gemv_done, mem_done} = 3'b000;
    repeat (2) @(negedge clk);
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++; $display("FAIL reset_outputs got=%h want=0", all_outs());
    end
    start = 1'b1; base_pc = 8'h33;
    @(negedge clk);
    vectors++;
    if ({busy, imem_req, pc} !== 10'd0) begin
      miscompares++; $display("FAIL reset_priority busy=%b req=%b pc=%h want 0/0/00", busy, imem_req, pc);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_halt();
    logic [63:0] iw;
    iw = rand_word(); iw[4:0] = 5'h01; iw[9:5] = 5'd3; iw[19:10] = 10'd16; iw[63:40] = 24'h000100;
    imem[0] = iw;
    iw = rand_word(); iw[4:0] = 5'h1F; imem[1] = iw;
    run_prog(8'h00, 500, 1'b1, 1'b0, 0);
    vectors++;
    if ({timed_out, pc, instr_count, error, halted, busy} !== {1'b0, 8'h01, 16'd2, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL load_halt_final to=%b pc=%h cnt=%0d err=%b halted=%b busy=%b want 0/01/2/0/1/0",
               timed_out, pc, instr_count, error, halted, busy);
    end
    vectors++;
    if (obs_q.size() != 1 || multi != 0) begin
      miscompares++; $display("FAIL load_halt_starts got=%0d extra=%0d want=1/0", obs_q.size(), multi);
    end else begin
      vectors++;
      if (obs_q[0] !== mk(2'd0, 2'b01, 5'd3, 10'd16, 10'd0, 24'h000100, 5'd0, 5'd0, 5'd0)) begin
        miscompares++; $display("FAIL load_halt_fields got=%h", obs_q[0]);
      end
    end
  endtask

  task automatic test_gemv();
    logic [63:0] iw;
    iw = rand_word(); iw[4:0] = 5'h04; iw[9:5] = 5'd5; iw[19:10] = 10'd64; iw[29:20] = 10'd32;
    iw[34:30] = 5'd1; iw[39:35] = 5'd2; iw[44:40] = 5'd4;
    imem[8'h20] = iw;
    iw = rand_word(); iw[4:0] = 5'h1F; imem[8'h21] = iw;
    run_prog(8'h20, 500, 1'b0, 1'b1, 10);
    vectors++;
    if (unstable != 0 || multi != 0 || timed_out) begin
      miscompares++;
      $display("FAIL gemv_hold unstable=%0d extra_starts=%0d to=%b want 0/0/0", unstable, multi, timed_out);
    end
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++; $display("FAIL gemv_count got=%0d want=1", obs_q.size());
    end else begin
      vectors++;
      if (obs_q[0] !== mk(2'd1, 2'd0, 5'd5, 10'd64, 10'd32, 24'd0, 5'd1, 5'd2, 5'd4)) begin
        miscompares++; $display("FAIL gemv_fields got=%h", obs_q[0]);
      end
    end
    vectors++;
    if ({pc, instr_count} !== {8'h21, 16'd2}) begin
      miscompares++; $display("FAIL gemv_final pc=%h cnt=%0d want 21/2", pc, instr_count);
    end
  endtask

  task automatic test_nop_relu();
    logic [63:0] iw;
    iw = rand_word(); iw[4:0] = 5'h00; imem[0] = iw;
    iw = rand_word(); iw[4:0] = 5'h05; iw[9:5] = 5'd6; iw[14:10] = 5'd2; iw[29:20] = 10'd32;
    imem[1] = iw;
    iw = rand_word(); iw[4:0] = 5'h1F; imem[2] = iw;
    run_prog(8'h00, 500, 1'b1, 1'b1, 0);
    vectors++;
    if (obs_q.size() != 1 || multi != 0) begin
      miscompares++; $display("FAIL nop_relu_starts got=%0d extra=%0d want=1/0", obs_q.size(), multi);
    end else begin
      vectors++;
      if (obs_q[0] !== mk(2'd2, 2'd0, 5'd6, 10'd32, 10'd0, 24'd0, 5'd0, 5'd2, 5'd0)) begin
        miscompares++; $display("FAIL nop_relu_fields got=%h", obs_q[0]);
      end
    end
    vectors++;
    if ({timed_out, pc, instr_count, halted} !== {1'b0, 8'h02, 16'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL nop_relu_final to=%b pc=%h cnt=%0d halted=%b want 0/02/3/1", timed_out, pc, instr_count, halted);
    end
  endtask

  task automatic test_illegal();
    logic [63:0] iw;
    for (int i = 0; i < 4; i++) begin iw = rand_word(); iw[4:0] = 5'h00; imem[i] = iw; end
    iw = rand_word(); iw[4:0] = 5'h0A; imem[4] = iw;
    run_prog(8'h00, 500, 1'b1, 1'b1, 0);
    vectors++;
    if ({timed_out, error, halted, busy, pc, instr_count} !== {1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 16'd4}
        || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL illegal_final to=%b err=%b halted=%b busy=%b pc=%h cnt=%0d starts=%0d want 0/1/1/0/04/4/0",
               timed_out, error, halted, busy, pc, instr_count, obs_q.size());
    end
    iw = rand_word(); iw[4:0] = 5'h1F; imem[8'h10] = iw;
    run_prog(8'h10, 500, 1'b0, 1'b0, 0);
    vectors++;
    if ({timed_out, error, halted, pc, instr_count} !== {1'b0, 1'b0, 1'b1, 8'h10, 16'd1}) begin
      miscompares++;
      $display("FAIL illegal_restart to=%b err=%b halted=%b pc=%h cnt=%0d want 0/0/1/10/1",
               timed_out, error, halted, pc, instr_count);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] iw;
    iw = rand_word(); iw[4:0] = 5'h00; imem[8'hFF] = iw;
    iw = rand_word(); iw[4:0] = 5'h1F; imem[8'h00] = iw;
    run_prog(8'hFF, 500, 1'b1, 1'b0, 0);
    vectors++;
    if ({timed_out, pc, instr_count, halted, error} !== {1'b0, 8'h00, 16'd2, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL pc_wrap to=%b pc=%h cnt=%0d halted=%b err=%b want 0/00/2/1/0",
               timed_out, pc, instr_count, halted, error);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] iw;
    logic [7:0]  pce;
    logic [15:0] cnte;
    logic        erre;
    for (int i = 0; i < 4; i++) begin
      iw = rand_word(); iw[4:0] = 5'($urandom_range(1, 5)); imem[8'h40 + 8'(i)] = iw;
    end
    iw = rand_word(); iw[4:0] = 5'h1F; imem[8'h44] = iw;
    model(8'h40, pce, cnte, erre);
    run_prog(8'h40, 1000, 1'b0, 1'b0, 0);
    vectors++;
    if (lat_q.size() != 3) begin
      miscompares++; $display("FAIL latency_count got=%0d want=3", lat_q.size());
    end
    foreach (lat_q[i]) begin
      vectors++;
      if (lat_q[i] != 3) begin
        miscompares++; $display("FAIL latency_%0d got=%0d cycles want=3", i, lat_q[i]);
      end
    end
    vectors++;
    if ({pc, instr_count} !== {pce, cnte}) begin
      miscompares++; $display("FAIL b2b_final pc=%h cnt=%0d want %h/%0d", pc, instr_count, pce, cnte);
    end
  endtask

  task automatic test_random_programs();
    logic [63:0] iw;
    logic [7:0]  bpc, pce;
    logic [15:0] cnte;
    logic        erre;
    int          n;
    for (int it = 0; it < 25; it++) begin
      bpc = 8'($urandom); n = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) begin
        iw = rand_word(); iw[4:0] = 5'($urandom_range(0, 5)); imem[8'(bpc + 8'(i))] = iw;
      end
      iw = rand_word();
      iw[4:0] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(6, 30)) : 5'h1F;
      imem[8'(bpc + 8'(n))] = iw;
      model(bpc, pce, cnte, erre);
      run_prog(bpc, 3000, 1'($urandom_range(0, 1)), 1'b1, 0);
      vectors++;
      if ({timed_out, pc, instr_count, error, halted, busy} !== {1'b0, pce, cnte, erre, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL rand%0d_final to=%b pc=%h cnt=%0d err=%b halted=%b busy=%b want 0/%h/%0d/%b/1/0",
                 it, timed_out, pc, instr_count, error, halted, busy, pce, cnte, erre);
      end
      vectors++;
      if (obs_q.size() != exp_q.size() || unstable != 0 || multi != 0) begin
        miscompares++;
        $display("FAIL rand%0d_dispatch starts=%0d want=%0d unstable=%0d extra=%0d",
                 it, obs_q.size(), exp_q.size(), unstable, multi);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL rand%0d_rec%0d got=%h want=%h", it, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [63:0] iw;
    bit          seen;
    iw = rand_word(); iw[4:0] = 5'h02; imem[0] = iw;
    @(negedge clk); start = 1'b1; base_pc = 8'h00;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      imem_valid = imem_req;
      if (mem_start) begin seen = 1; break; end
      @(negedge clk);
    end
    imem_valid = 1'b0;
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL rst_mid_dispatch got=no mem_start want=mem_start within 50 cycles");
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_waiting busy=%b want=1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++; $display("FAIL rst_mid_outputs got=%h want=0", all_outs());
    end
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++; $display("FAIL rst_mid_late_done got=%h want=0", all_outs());
    end
  endtask

  initial begin
    test_reset();
    test_load_halt();
    test_gemv();
    test_nop_relu();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_random_programs();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, instruction-memory word-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin execution at base_pc; honoured only in IDLE or HALTED.
REQ-005 SHALL have port base_pc  input  PC_W  first instruction address.
REQ-006 SHALL have port imem_req  output  1  fetch request, held until imem_valid.
REQ-007 SHALL have port imem_addr  output  PC_W  fetch address (equals pc).
REQ-008 SHALL have port imem_rdata  input  64  instruction word, sampled when imem_valid=1.
REQ-009 SHALL have port imem_valid  input  1  fetch data valid.
REQ-010 SHALL have ports mem_start, gemv_start, relu_start  output  1 each  one-cycle dispatch pulses.
REQ-011 SHALL have port mem_op  output  2  01 LOAD_V, 10 LOAD_M, 11 STORE, 00 otherwise.
REQ-012 SHALL have ports mem_done, gemv_done, relu_done  input  1 each  unit completion pulses.
REQ-013 SHALL have registered field outputs dest(5), len_cols(10), rows(10), addr(24), b(5), x(5), w(5).
REQ-014 SHALL have outputs busy(1), halted(1), error(1), pc(PC_W), instr_count(16).

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, DISPATCH, WAIT_DONE, HALTED.
REQ-016 IDLE/HALTED + start: pc<=base_pc, error<=0, instr_count<=0, next state FETCH.
REQ-017 FETCH: imem_req=1, imem_addr=pc; stay until imem_valid=1, then latch imem_rdata and go to DECODE.
REQ-018 DECODE (exactly one cycle): opcode=instr[4:0]; load field registers; fields unused by the opcode SHALL be 0.
REQ-019 Opcode 01 LOAD_V / 03 STORE: dest=[9:5], len_cols=[19:10], addr=[63:40].
REQ-020 Opcode 02 LOAD_M: as LOAD_V, plus rows=[29:20].
REQ-021 Opcode 04 GEMV: dest=[9:5], len_cols=[19:10], rows=[29:20], b=[34:30], x=[39:35], w=[44:40].
REQ-022 Opcode 05 RELU: dest=[9:5], x=[14:10], len_cols=[29:20].
REQ-023 Opcode 00 NOP: pc<=pc+1, instr_count+1, go to FETCH; no start pulse.
REQ-024 Opcode 1F HALT: go to HALTED; halted=1; pc is not incremented; instr_count+1.
REQ-025 Any other opcode: error<=1 (sticky until next accepted start); go to HALTED; instr_count unchanged.
REQ-026 DISPATCH (one cycle): assert exactly one start pulse for the decoded unit; set mem_op; go to WAIT_DONE.
REQ-027 WAIT_DONE: hold all field outputs and mem_op stable; wait for the selected unit's done pulse.
REQ-028 On the done pulse: pc<=pc+1, instr_count+1, go to FETCH.
REQ-029 Done pulses from non-selected units, and any done pulse outside WAIT_DONE, SHALL be ignored.
REQ-030 Done arriving in the same cycle as the start pulse SHALL be ignored; done is valid from the next cycle onward.
REQ-031 Minimum latency from done to next start pulse: FETCH (≥1 cycle) + DECODE + DISPATCH, i.e. 3 cycles when imem_valid is immediate.
REQ-032 pc SHALL wrap from 2^PC_W-1 to 0; instr_count SHALL wrap modulo 2^16.
REQ-033 busy=1 in every state except IDLE and HALTED; halted=1 only in HALTED.
REQ-034 start SHALL be ignored while busy=1.

Reset
REQ-035 rst=1 at any clock edge, including mid-operation: state<=IDLE; all outputs 0; pc=0; instr_count=0; pending done pulses discarded.
REQ-036 Reset SHALL take priority over start and all other inputs in the same cycle.

Verification
REQ-037 LOAD_V dest=3, len=16, addr=0x000100 at pc 0, then HALT -> one mem_start pulse, mem_op=01, dest=3, len_cols=16, addr=0x100; after mem_done, HALT at pc 1 sets halted=1; instr_count=2.
REQ-038 GEMV cols=64, rows=32, b=1, x=2, w=4, dest=5; gemv_done held off 10 cycles -> fields stable throughout; no other start pulse; relu_done injected mid-wait is ignored.
REQ-039 Sequence NOP, RELU(x=2, len=32, dest=6), HALT -> no start pulse for the NOP; relu_start one pulse with len_cols=32, x=2; final pc=2.
REQ-040 Opcode 0x0A at pc 4 -> error=1, halted=1, no start pulse; a subsequent start clears error and refetches from base_pc.
REQ-041 rst asserted during WAIT_DONE of LOAD_M -> next cycle IDLE with all outputs 0; a late mem_done causes no transition.
REQ-042 PC_W=8, base_pc=0xFF with NOP then HALT at address 0x00 -> pc wraps to 0x00 and the block halts.
